// File: rtl/result_streamer_pkg.sv
// -----------------------------------------------------------------------------
// result_streamer_pkg
// Shared constants for the result streamer: datapath operand width, result RAM
// geometry, derived byte/entry counts and the streamer FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package result_streamer_pkg;

   // Operand width of the approximate multiplier; results are 2N bits wide.
   localparam int N              = 16;
   // Result RAM address is K+1 bits wide.
   localparam int K              = 3;

   localparam int RES_W          = 2 * N;
   localparam int ENT_W          = K + 1;
   localparam int BYTES_PER_WORD = RES_W / 8;
   localparam int ENTRIES        = 2 ** ENT_W;

   // A single-byte word still needs a 1-bit byte counter to stay legal.
   localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   // FSM state encoding.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_READ = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      READ = ST_READ,
      WAIT = ST_WAIT,
      SEND = ST_SEND,
      DONE = ST_DONE
   } state_t;

   // Most significant byte of a result word: the byte currently on the wire.
   function automatic logic [7:0] top_byte(input logic [RES_W-1:0] word);
      return word[RES_W-1 -: 8];
   endfunction

endpackage

// File: rtl/result_streamer_counter.sv
// -----------------------------------------------------------------------------
// result_streamer_counter
// Generic up-counter with synchronous clear, load and count enable.
// Priority: rst > clr > ld > cnten.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   clr     in   clear to zero
//   ld      in   load ld_val
//   ld_val  in   W  load value
//   cnten   in   increment by one
//   q       out  W  current count (register output)
//   ov      out  terminal count: q is all ones, next increment would wrap
// -----------------------------------------------------------------------------
module result_streamer_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         cnten,
   output logic [W-1:0] q,
   output logic         ov
);

   logic [W-1:0] q_r;

   // Count register with clear/load/increment priority chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= {W{1'b0}};
      end else if (clr) begin
         q_r <= {W{1'b0}};
      end else if (ld) begin
         q_r <= ld_val;
      end else if (cnten) begin
         q_r <= q_r + W'(1);
      end else begin
         q_r <= q_r;
      end
   end

   assign q  = q_r;
   assign ov = &q_r;

endmodule

// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
// Reads every entry of the result RAM after a batch completes and sends each
// 2N-bit result as a byte stream (MSB first) over a valid/ready interface.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to stream the whole RAM (ignored unless idle)
//   busy       out  a stream is in progress
//   ram_rd_en  out  read strobe to the result RAM
//   ram_addr   out  ENT_W  read address (holds outside reads)
//   ram_data   in   RES_W  read data, valid one cycle after ram_rd_en
//   tx_data    out  8  current byte
//   tx_valid   out  tx_data is valid
//   tx_ready   in   sink accepts the byte on tx_valid & tx_ready
//   tx_last    out  marks the final byte of the final entry
//   finished   out  one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module result_streamer
   import result_streamer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             ram_rd_en,
   output logic [ENT_W-1:0] ram_addr,
   input  logic [RES_W-1:0] ram_data,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_last,
   output logic             finished
);

   localparam logic [BCNT_W-1:0] BCNT_LAST   = BCNT_W'(BYTES_PER_WORD - 1);
   localparam logic [BCNT_W-1:0] BCNT_PENULT = BCNT_W'((BYTES_PER_WORD > 1) ? (BYTES_PER_WORD - 2) : 0);

   state_t             state_r;
   logic               busy_r;
   logic               rd_en_r;
   logic [ENT_W-1:0]   addr_r;
   logic [RES_W-1:0]   shift_r;
   logic               valid_r;
   logic               last_r;
   logic               fin_r;

   logic [ENT_W-1:0]   entry_q_s;
   logic               ent_ov_s;
   logic [BCNT_W-1:0]  byte_q_s;
   logic               byte_ov_s;

   logic               hs_s;
   logic               last_byte_s;
   logic               ent_clr_s;
   logic               ent_en_s;
   logic               byte_clr_s;
   logic               byte_en_s;

   assign hs_s        = valid_r & tx_ready;
   assign last_byte_s = (byte_q_s == BCNT_LAST);

   // Counter control decode. The entry counter stops at its terminal count,
   // which is what ends the stream, so it is never advanced past max.
   always_comb begin
      ent_clr_s  = 1'b0;
      ent_en_s   = 1'b0;
      byte_clr_s = 1'b0;
      byte_en_s  = 1'b0;
      case (state_r)
         IDLE: begin
            ent_clr_s = start;
         end
         WAIT: begin
            byte_clr_s = 1'b1;
         end
         SEND: begin
            byte_en_s = hs_s;
            ent_en_s  = hs_s & last_byte_s & ~ent_ov_s;
         end
         default: begin
            ent_clr_s  = 1'b0;
            byte_clr_s = 1'b0;
         end
      endcase
   end

   result_streamer_counter #(.W(ENT_W)) u_entry_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (ent_clr_s),
      .ld     (1'b0),
      .ld_val ({ENT_W{1'b0}}),
      .cnten  (ent_en_s),
      .q      (entry_q_s),
      .ov     (ent_ov_s)
   );

   result_streamer_counter #(.W(BCNT_W)) u_byte_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (byte_clr_s),
      .ld     (1'b0),
      .ld_val ({BCNT_W{1'b0}}),
      .cnten  (byte_en_s),
      .q      (byte_q_s),
      .ov     (byte_ov_s)
   );

   // FSM with registered outputs. Outputs are set on the edge that enters the
   // state that owns them, so each one is a plain flop at the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         rd_en_r <= 1'b0;
         addr_r  <= {ENT_W{1'b0}};
         shift_r <= {RES_W{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         fin_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= READ;
                  busy_r  <= 1'b1;
                  rd_en_r <= 1'b1;
                  addr_r  <= {ENT_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            READ: begin
               rd_en_r <= 1'b0;
               state_r <= WAIT;
            end
            WAIT: begin
               shift_r <= ram_data;
               valid_r <= 1'b1;
               last_r  <= ent_ov_s & (BYTES_PER_WORD == 1);
               state_r <= SEND;
            end
            SEND: begin
               if (hs_s) begin
                  // Shifting in zeros leaves tx_data at 0 once a word is drained.
                  shift_r <= {shift_r[RES_W-9:0], 8'h00};
                  if (last_byte_s) begin
                     valid_r <= 1'b0;
                     last_r  <= 1'b0;
                     if (ent_ov_s) begin
                        state_r <= DONE;
                        fin_r   <= 1'b1;
                     end else begin
                        // Entry counter advances on this same edge.
                        state_r <= READ;
                        rd_en_r <= 1'b1;
                        addr_r  <= entry_q_s + ENT_W'(1);
                     end
                  end else begin
                     // Next byte becomes the last one of the stream.
                     last_r <= ent_ov_s & (byte_q_s == BCNT_PENULT);
                  end
               end else begin
                  state_r <= SEND;
               end
            end
            DONE: begin
               fin_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign ram_rd_en = rd_en_r;
   assign ram_addr  = addr_r;
   assign tx_data   = top_byte(shift_r);
   assign tx_valid  = valid_r;
   assign tx_last   = last_r;
   assign finished  = fin_r;

endmodule

// File: tb/tb_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_streamer
// Self-checking bench: a table of stream scenarios (RAM contents, sink ready
// pattern, extra start pulses) checked cycle by cycle against a timeline model
// built from the streaming rules, plus a hand-written mid-stream reset sequence.
// -----------------------------------------------------------------------------
module tb_result_streamer;
   import result_streamer_pkg::*;

   localparam int MAXC = 640;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             ram_rd_en;
   logic [ENT_W-1:0] ram_addr;
   logic [RES_W-1:0] ram_data;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_last;
   logic             finished;

   logic [31:0] mem [16];

   int tests = 0;
   int fails = 0;

   // Per-cycle stimulus and expected timeline (index = cycle after start edge).
   bit          rdy_a   [MAXC];
   bit          st_a    [MAXC];
   bit          e_valid [MAXC];
   bit          e_last  [MAXC];
   bit          e_fin   [MAXC];
   bit          e_busy  [MAXC];
   bit          e_rd    [MAXC];
   logic [7:0]  e_data  [MAXC];
   logic [3:0]  e_addr  [MAXC];
   int          e_end;

   typedef struct {
      int          pat;        // 0: 0x11223300+i, 1: corner words, 2: random
      int          mode;       // 0: ready=1, 1: ready toggles 1,0,..., 2: random
      int          start_len;  // cycles start is held from cycle 0
      int          x1;         // extra start pulse cycle (0 = none)
      int          x2;
      int          exp_fin;    // finished cycle, 0 = model only
      bit          chk_words;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      int          exp_rd;
   } vec_t;

   vec_t tbl [6];

   result_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .ram_rd_en (ram_rd_en),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_last   (tx_last),
      .finished  (finished)
   );

   always #5 clk = ~clk;

   // Result RAM: one-cycle registered read.
   always @(posedge clk) begin
      if (ram_rd_en) ram_data <= mem[ram_addr];
   end

   task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
      end
   endtask

   task automatic fill_mem(input int pat);
      for (int i = 0; i < 16; i++) begin
         if (pat == 2) mem[i] = $urandom;
         else          mem[i] = 32'h11223300 + 32'(i);
      end
      if (pat == 1) begin
         mem[0]  = 32'hFFFFFFFF;
         mem[15] = 32'h00000001;
      end
   endtask

   // Timeline from the rules: each entry spends one READ and one WAIT cycle,
   // then each byte waits in SEND until a cycle where the sink is ready; one
   // DONE cycle follows the final byte.
   task automatic build_model();
      int c;
      for (int i = 0; i < MAXC; i++) begin
         e_valid[i] = 0; e_last[i] = 0; e_fin[i] = 0; e_busy[i] = 0; e_rd[i] = 0;
         e_data[i] = 8'h00; e_addr[i] = 4'h0;
      end
      c = 1;
      for (int e = 0; e < 16; e++) begin
         e_rd[c] = 1; e_addr[c] = 4'(e); e_busy[c] = 1; c++;
         e_busy[c] = 1; c++;
         for (int b = 0; b < 4; b++) begin
            logic [31:0] w;
            w = mem[e] >> (8 * (3 - b));
            while (1) begin
               e_valid[c] = 1; e_data[c] = w[7:0];
               e_last[c] = (e == 15) && (b == 3);
               e_busy[c] = 1;
               if (rdy_a[c]) begin c++; break; end
               c++;
            end
         end
      end
      e_fin[c] = 1; e_busy[c] = 1; c++;
      e_end = c;
   endtask

   task automatic run_stream(input int mode, input int start_len, input int x1, input int x2,
                             output int fin_cyc, output int rd_cnt, output int nbytes,
                             output logic [31:0] w_first, output logic [31:0] w_last);
      logic [7:0] q [$];
      for (int c = 0; c < MAXC; c++) begin
         case (mode)
            0:       rdy_a[c] = 1;
            1:       rdy_a[c] = (c % 2) == 1;
            default: rdy_a[c] = ((c % 4) == 0) || ($urandom_range(0, 3) != 0);
         endcase
         st_a[c] = (c < start_len) || (x1 != 0 && c == x1) || (x2 != 0 && c == x2);
      end
      build_model();
      fin_cyc = -1; rd_cnt = 0;
      for (int c = 0; c <= e_end + 4; c++) begin
         start    = st_a[c];
         tx_ready = rdy_a[c];
         check("tx_valid", c, 32'(tx_valid), 32'(e_valid[c]));
         check("tx_last", c, 32'(tx_last), 32'(e_last[c]));
         check("finished", c, 32'(finished), 32'(e_fin[c]));
         check("busy", c, 32'(busy), 32'(e_busy[c]));
         check("ram_rd_en", c, 32'(ram_rd_en), 32'(e_rd[c]));
         if (e_rd[c])    check("ram_addr", c, 32'(ram_addr), 32'(e_addr[c]));
         if (e_valid[c]) check("tx_data", c, 32'(tx_data), 32'(e_data[c]));
         if (tx_valid && tx_ready) q.push_back(tx_data);
         if (finished) fin_cyc = c;
         if (ram_rd_en) rd_cnt++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      tx_ready = 1'b1;
      nbytes = q.size();
      if (nbytes >= 64) begin
         w_first = {q[0], q[1], q[2], q[3]};
         w_last  = {q[60], q[61], q[62], q[63]};
      end else begin
         w_first = 32'h0; w_last = 32'h0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fin_cyc, rd_cnt, nbytes, fin_seen, busy_seen;
      logic [31:0] wf, wl;

      tbl[0] = '{0, 0, 1, 0,  0,  97, 1, 32'h11223300, 32'h1122330F, 16};
      tbl[1] = '{0, 1, 1, 0,  0, 160, 1, 32'h11223300, 32'h1122330F, 16};
      tbl[2] = '{0, 0, 1, 10, 50, 97, 1, 32'h11223300, 32'h1122330F, 16};
      tbl[3] = '{1, 0, 1, 0,  0,  97, 1, 32'hFFFFFFFF, 32'h00000001, 16};
      tbl[4] = '{0, 0, 3, 0,  0,  97, 1, 32'h11223300, 32'h1122330F, 16};
      tbl[5] = '{2, 2, 1, 0,  0,   0, 0, 32'h0,        32'h0,        16};

      rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
      fill_mem(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 0, 32'(busy), 32'h0);
      check("rst ram_rd_en", 0, 32'(ram_rd_en), 32'h0);
      check("rst ram_addr", 0, 32'(ram_addr), 32'h0);
      check("rst tx_data", 0, 32'(tx_data), 32'h0);
      check("rst tx_valid", 0, 32'(tx_valid), 32'h0);
      check("rst tx_last", 0, 32'(tx_last), 32'h0);
      check("rst finished", 0, 32'(finished), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 6; t++) begin
         fill_mem(tbl[t].pat);
         run_stream(tbl[t].mode, tbl[t].start_len, tbl[t].x1, tbl[t].x2, fin_cyc, rd_cnt, nbytes, wf, wl);
         check($sformatf("row%0d byte count", t), t, 32'(nbytes), 32'd64);
         check($sformatf("row%0d rd_en pulses", t), t, 32'(rd_cnt), 32'(tbl[t].exp_rd));
         check($sformatf("row%0d finished cycle vs model", t), t, 32'(fin_cyc), 32'(e_end - 1));
         if (tbl[t].exp_fin != 0)
            check($sformatf("row%0d finished cycle", t), t, 32'(fin_cyc), 32'(tbl[t].exp_fin));
         if (tbl[t].chk_words) begin
            check($sformatf("row%0d first word", t), t, wf, tbl[t].exp_first);
            check($sformatf("row%0d last word", t), t, wl, tbl[t].exp_last);
         end
      end

      // Reset in the middle of a stream: abandon it, no finished pulse.
      fill_mem(0);
      for (int c = 0; c <= 40; c++) begin
         start    = (c == 0);
         tx_ready = 1'b1;
         rst      = (c == 40);
         @(posedge clk); #1;
      end
      rst = 1'b0; start = 1'b0;
      check("midrst busy", 41, 32'(busy), 32'h0);
      check("midrst ram_rd_en", 41, 32'(ram_rd_en), 32'h0);
      check("midrst ram_addr", 41, 32'(ram_addr), 32'h0);
      check("midrst tx_data", 41, 32'(tx_data), 32'h0);
      check("midrst tx_valid", 41, 32'(tx_valid), 32'h0);
      check("midrst tx_last", 41, 32'(tx_last), 32'h0);
      check("midrst finished", 41, 32'(finished), 32'h0);
      fin_seen = 0; busy_seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (finished) fin_seen++;
         if (busy || tx_valid || ram_rd_en) busy_seen++;
         @(posedge clk); #1;
      end
      check("midrst no finished", 0, 32'(fin_seen), 32'h0);
      check("midrst stays idle", 0, 32'(busy_seen), 32'h0);
      run_stream(0, 1, 0, 0, fin_cyc, rd_cnt, nbytes, wf, wl);
      check("restart byte count", 0, 32'(nbytes), 32'd64);
      check("restart finished cycle", 0, 32'(fin_cyc), 32'd97);
      check("restart first word", 0, wf, 32'h11223300);
      check("restart last word", 0, wl, 32'h1122330F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
